dff_write_arbiter: RTL and testbench
====================================

DFF_WRITE_ARBITER -- requirements
Module: dff_write_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters (2..8).
REQ-002 Parameter W, default 8, width of the shared register.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req  input  NREQ  per-requester write request; bit i belongs to requester i.
REQ-006 wdata  input  NREQ*W  write data; slice [i*W +: W] belongs to requester i.
REQ-007 gnt  output  NREQ  registered one-hot grant, asserted for exactly one cycle per write.
REQ-008 q  output  W  contents of the shared enable-gated register.
REQ-009 owner  output  3  index of the requester that last wrote q.
REQ-010 busy  output  1  high while the FSM is in GRANT.
REQ-011 wr_count  output  16  number of completed writes, saturating at 16'hFFFF.

Function
REQ-012 The FSM SHALL have two states: IDLE and GRANT.
REQ-013 In IDLE at edge k with any req bit high, the arbiter SHALL select winner w round-robin, searching from ptr upward with wrap-around; it SHALL then set gnt[w]=1, set busy=1 and enter GRANT.
REQ-014 In IDLE with req == 0, all state SHALL hold and gnt SHALL stay 0.
REQ-015 In GRANT, the shared register's enable SHALL be 1 and its d SHALL be wdata slice w, muxed from the registered winner index.
REQ-016 At edge k+1 the following SHALL all happen:
  - q <= wdata slice w;
  - owner <= w;
  - ptr <= (w+1) mod NREQ;
  - wr_count increments unless saturated;
  - gnt <= 0, busy <= 0, FSM returns to IDLE.
REQ-017 Latency: req high before edge k gives q updated at edge k+1; sustained throughput is one write per 2 cycles.
REQ-018 A grant, once issued, SHALL complete even if req[w] drops during GRANT; the data written is wdata as sampled at edge k+1.
REQ-019 req is ignored while the FSM is in GRANT; new arbitration occurs only from IDLE.
REQ-020 A requester SHALL hold req and wdata stable until it sees gnt; req dropped before edge k yields no grant.
REQ-021 With all requesters continuously requesting, grants SHALL rotate 0,1,...,NREQ-1,0 with no starvation: worst-case wait is 2*NREQ cycles.
REQ-022 The register enable SHALL be 0 in IDLE; q SHALL never change outside a GRANT cycle or reset.

Reset
REQ-023 While rst is high at a rising edge, the block SHALL set q=0, gnt=0, busy=0, owner=0, wr_count=0, ptr=0 and the FSM to IDLE.
REQ-024 Reset SHALL take priority over an in-flight GRANT: the write is dropped, q becomes 0 and wr_count does not increment.
REQ-025 The first arbitration after reset SHALL favour requester 0.

Structure
REQ-026 The shared package SHALL hold the FSM state typedef (IDLE, GRANT) and the wr_count width constant (16).
REQ-027 The shared register SHALL be a sub-module dff_en_reg with ports clk, rst, en, d[W] and q[W]; it uses synchronous active-high reset to 0 and loads d when en is 1.
REQ-028 The arbiter SHALL use no combinational path from req to gnt; gnt SHALL come straight from flops.

Verification
REQ-029 Reset: assert rst for 3 cycles with req=4'b1111 -> q=0, gnt=0, busy=0 and wr_count=0 throughout, and no write is performed.
REQ-030 Single write: req=4'b0100 with wdata slice 2 = 8'hA5 -> gnt=4'b0100 one cycle later, then q=8'hA5, owner=2 and wr_count=1 on the following edge.
REQ-031 Round-robin: req=4'b1111 held for 8 cycles from reset -> grants go to 0,1,2,3, with gnt pulses every 2 cycles and wr_count=4.
REQ-032 Withdrawal: requester 1 drops req during its GRANT cycle -> the write still completes (q = slice 1) and no second grant is issued to requester 1.
REQ-033 Reset mid-operation: rst asserted in the GRANT cycle with wdata slice 0 = 8'h3C -> q=0, wr_count=0 and the FSM is in IDLE next cycle.
REQ-034 Saturation: force wr_count to 16'hFFFE, perform 3 writes -> wr_count ends at 16'hFFFF.

Source files
------------

// File: rtl/dff_write_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// dff_write_arbiter_pkg
//   Shared definitions for the write arbiter:
//     - state_t      : two-state arbiter FSM encoding (ST_IDLE, ST_GRANT)
//     - WR_CNT_W     : width of the completed-write counter (16)
//     - OWNER_W      : width of requester indices (covers up to 8 requesters)
//     - MAX_NREQ     : largest supported requester count
//     - rr_pick()    : round-robin winner search starting at a pointer
// ---------------------------------------------------------------------------
package dff_write_arbiter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam int WR_CNT_W = 16;
  localparam int OWNER_W  = 3;
  localparam int MAX_NREQ = 8;

  // Search requesters starting at ptr and moving upward with wrap-around at
  // nreq. Returns the first requesting index. The caller gates the result
  // with |req, so the value returned for an all-zero request is a don't-care.
  function automatic logic [OWNER_W-1:0] rr_pick(
    input logic [MAX_NREQ-1:0] req,
    input logic [OWNER_W-1:0]  ptr,
    input int                  nreq
  );
    logic               found;
    int                 idx;
    logic [OWNER_W-1:0] idx3;
    logic [OWNER_W-1:0] pick;
    found = 1'b0;
    pick  = '0;
    for (int i = 0; i < MAX_NREQ; i++) begin
      idx  = (int'(ptr) + i) % nreq;
      idx3 = OWNER_W'(idx);
      if (!found && (i < nreq) && req[idx3]) begin
        found = 1'b1;
        pick  = idx3;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/dff_write_arbiter_dff_en_reg.sv
// ---------------------------------------------------------------------------
// dff_en_reg
//   Enable-gated register holding the shared value written by the arbiter.
//   Ports:
//     clk  in   rising-edge clock
//     rst  in   synchronous active-high reset, clears q to 0
//     en   in   load enable
//     d    in   [W] data loaded when en is high
//     q    out  [W] register contents
// ---------------------------------------------------------------------------
module dff_en_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (en) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/dff_write_arbiter.sv
// ---------------------------------------------------------------------------
// dff_write_arbiter
//   Round-robin arbiter granting NREQ requesters write access to one shared
//   W-bit register. A write takes two cycles: arbitration in IDLE (grant
//   registered), then the GRANT cycle where the register loads the winner's
//   data slice. Sustained throughput is one write every two cycles.
//   Ports:
//     clk       in   rising-edge clock
//     rst       in   synchronous active-high reset
//     req       in   [NREQ]   per-requester write request
//     wdata     in   [NREQ*W] write data, slice [i*W +: W] for requester i
//     gnt       out  [NREQ]   registered one-hot grant, one cycle per write
//     q         out  [W]      shared register contents
//     owner     out  [3]      index of requester that last wrote q
//     busy      out           high while in GRANT
//     wr_count  out  [16]     completed writes, saturating at all-ones
// ---------------------------------------------------------------------------
module dff_write_arbiter
  import dff_write_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req,
  input  logic [NREQ*W-1:0]   wdata,
  output logic [NREQ-1:0]     gnt,
  output logic [W-1:0]        q,
  output logic [2:0]          owner,
  output logic                busy,
  output logic [WR_CNT_W-1:0] wr_count
);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  state_t               r_state;
  logic [NREQ-1:0]      r_gnt;
  logic                 r_busy;
  logic [OWNER_W-1:0]   r_win;       // winner latched at arbitration
  logic [OWNER_W-1:0]   r_owner;
  logic [OWNER_W-1:0]   r_ptr;       // round-robin search start
  logic [WR_CNT_W-1:0]  r_wr_count;

  state_t               w_state_next;
  logic [NREQ-1:0]      w_gnt_next;
  logic                 w_busy_next;
  logic [OWNER_W-1:0]   w_win_next;
  logic [OWNER_W-1:0]   w_owner_next;
  logic [OWNER_W-1:0]   w_ptr_next;
  logic [WR_CNT_W-1:0]  w_wr_count_next;

  logic                 w_any_req;
  logic [OWNER_W-1:0]   w_pick;
  logic [NREQ-1:0]      w_pick_onehot;
  logic                 w_reg_en;
  logic [W-1:0]         w_reg_d;
  logic [W-1:0]         w_slice [NREQ];

  // -------------------------------------------------------------------------
  // Write data slices per requester
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slice
      assign w_slice[gi] = wdata[gi*W +: W];
    end
  endgenerate

  // The data mux is driven from the registered winner, not from req, so the
  // write completes even if the winner withdraws during GRANT.
  always_comb begin
    w_reg_d = w_slice[0];
    for (int i = 1; i < NREQ; i++) begin
      if (r_win == OWNER_W'(i)) begin
        w_reg_d = w_slice[i];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Arbitration
  // -------------------------------------------------------------------------
  assign w_any_req     = |req;
  assign w_pick        = rr_pick(MAX_NREQ'(req), r_ptr, NREQ);
  assign w_pick_onehot = {{(NREQ-1){1'b0}}, 1'b1} << w_pick;

  // -------------------------------------------------------------------------
  // FSM next-state and datapath control
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next    = r_state;
    w_gnt_next      = '0;
    w_busy_next     = 1'b0;
    w_win_next      = r_win;
    w_owner_next    = r_owner;
    w_ptr_next      = r_ptr;
    w_wr_count_next = r_wr_count;
    w_reg_en        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_win_next   = w_pick;
          w_gnt_next   = w_pick_onehot;
          w_busy_next  = 1'b1;
          w_state_next = ST_GRANT;
        end
      end

      ST_GRANT: begin
        // req is not looked at here; the latched winner finishes its write.
        w_reg_en     = 1'b1;
        w_owner_next = r_win;
        w_ptr_next   = (r_win == OWNER_W'(NREQ-1)) ? '0 : r_win + 1'b1;
        if (r_wr_count != {WR_CNT_W{1'b1}}) begin
          w_wr_count_next = r_wr_count + 1'b1;
        end
        w_state_next = ST_IDLE;
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_gnt      <= '0;
      r_busy     <= 1'b0;
      r_win      <= '0;
      r_owner    <= '0;
      r_ptr      <= '0;
      r_wr_count <= '0;
    end else begin
      r_state    <= w_state_next;
      r_gnt      <= w_gnt_next;
      r_busy     <= w_busy_next;
      r_win      <= w_win_next;
      r_owner    <= w_owner_next;
      r_ptr      <= w_ptr_next;
      r_wr_count <= w_wr_count_next;
    end
  end

  // -------------------------------------------------------------------------
  // Shared register
  // -------------------------------------------------------------------------
  dff_en_reg #(
    .W (W)
  ) u_shared_reg (
    .clk (clk),
    .rst (rst),
    .en  (w_reg_en),
    .d   (w_reg_d),
    .q   (q)
  );

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign gnt      = r_gnt;
  assign busy     = r_busy;
  assign owner    = r_owner;
  assign wr_count = r_wr_count;

endmodule

// File: tb/tb_dff_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dff_write_arbiter
//   Self-checking bench for dff_write_arbiter (NREQ=4, W=8): a table of
//   hand-derived vectors, hand-written corner sequences, then random traffic
//   compared against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_dff_write_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 8;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [NREQ*W-1:0] wdata;
  logic [NREQ-1:0]   gnt;
  logic [W-1:0]      q;
  logic [2:0]        owner;
  logic              busy;
  logic [15:0]       wr_count;

  int total;
  int bad;

  dff_write_arbiter #(
    .NREQ (NREQ),
    .W    (W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .wdata    (wdata),
    .gnt      (gnt),
    .q        (q),
    .owner    (owner),
    .busy     (busy),
    .wr_count (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // -------------------------------------------------------------------------
  // Reference model: a write is "pending" (with a known winner) for the one
  // cycle after it is granted; when it completes the shared value, owner,
  // pointer and count update.
  // -------------------------------------------------------------------------
  logic        m_pending;
  int          m_win;
  int          m_ptr;
  logic [7:0]  m_q;
  int          m_owner;
  int          m_cnt;
  logic [3:0]  m_gnt;

  task automatic model_reset();
    m_pending = 1'b0;
    m_win     = 0;
    m_ptr     = 0;
    m_q       = 8'h00;
    m_owner   = 0;
    m_cnt     = 0;
    m_gnt     = 4'b0000;
  endtask

  task automatic model_step(input logic r, input logic [3:0] rq, input logic [31:0] wd);
    if (r) begin
      model_reset();
    end else if (m_pending) begin
      m_q       = wd[m_win*8 +: 8];
      m_owner   = m_win;
      m_ptr     = (m_win + 1) % NREQ;
      if (m_cnt < 65535) m_cnt = m_cnt + 1;
      m_pending = 1'b0;
      m_gnt     = 4'b0000;
      $display("write: owner=%0d data=%h count=%0d", m_owner, m_q, m_cnt);
    end else begin
      m_gnt = 4'b0000;
      for (int k = 0; k < NREQ; k++) begin
        int c;
        c = (m_ptr + k) % NREQ;
        if (!m_pending && rq[c]) begin
          m_pending = 1'b1;
          m_win     = c;
          m_gnt     = 4'(1 << c);
        end
      end
    end
  endtask

  // -------------------------------------------------------------------------
  // Helpers
  // -------------------------------------------------------------------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Drive inputs on the falling edge, advance the model, sample 1 after rise.
  task automatic cycle(input logic r, input logic [3:0] rq, input logic [31:0] wd);
    @(negedge clk);
    rst   = r;
    req   = rq;
    wdata = wd;
    model_step(r, rq, wd);
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_gnt"},   32'(gnt),      32'(m_gnt));
    chk({tag, "_q"},     32'(q),        32'(m_q));
    chk({tag, "_owner"}, 32'(owner),    32'(m_owner));
    chk({tag, "_busy"},  32'(busy),     32'(m_pending));
    chk({tag, "_cnt"},   32'(wr_count), 32'(m_cnt));
  endtask

  // -------------------------------------------------------------------------
  // Table of vectors (expected values derived by hand)
  // -------------------------------------------------------------------------
  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [31:0] wdata;
    logic [3:0]  exp_gnt;
    logic [7:0]  exp_q;
    logic [2:0]  exp_owner;
    logic        exp_busy;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs [15];

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    req   = '0;
    wdata = '0;
    model_reset();

    // reset held 3 cycles with all requesting: nothing happens
    vecs[0]  = '{1'b1, 4'b1111, 32'hDEADBEEF, 4'b0000, 8'h00, 3'd0, 1'b0, 16'd0};
    vecs[1]  = '{1'b1, 4'b1111, 32'hDEADBEEF, 4'b0000, 8'h00, 3'd0, 1'b0, 16'd0};
    vecs[2]  = '{1'b1, 4'b1111, 32'hDEADBEEF, 4'b0000, 8'h00, 3'd0, 1'b0, 16'd0};
    // single write from requester 2
    vecs[3]  = '{1'b0, 4'b0100, 32'h00A50000, 4'b0100, 8'h00, 3'd0, 1'b1, 16'd0};
    vecs[4]  = '{1'b0, 4'b0100, 32'h00A50000, 4'b0000, 8'hA5, 3'd2, 1'b0, 16'd1};
    vecs[5]  = '{1'b0, 4'b0000, 32'h00A50000, 4'b0000, 8'hA5, 3'd2, 1'b0, 16'd1};
    // reset, then everyone requests for 8 cycles: rotation 0,1,2,3
    vecs[6]  = '{1'b1, 4'b0000, 32'h44332211, 4'b0000, 8'h00, 3'd0, 1'b0, 16'd0};
    vecs[7]  = '{1'b0, 4'b1111, 32'h44332211, 4'b0001, 8'h00, 3'd0, 1'b1, 16'd0};
    vecs[8]  = '{1'b0, 4'b1111, 32'h44332211, 4'b0000, 8'h11, 3'd0, 1'b0, 16'd1};
    vecs[9]  = '{1'b0, 4'b1111, 32'h44332211, 4'b0010, 8'h11, 3'd0, 1'b1, 16'd1};
    vecs[10] = '{1'b0, 4'b1111, 32'h44332211, 4'b0000, 8'h22, 3'd1, 1'b0, 16'd2};
    vecs[11] = '{1'b0, 4'b1111, 32'h44332211, 4'b0100, 8'h22, 3'd1, 1'b1, 16'd2};
    vecs[12] = '{1'b0, 4'b1111, 32'h44332211, 4'b0000, 8'h33, 3'd2, 1'b0, 16'd3};
    vecs[13] = '{1'b0, 4'b1111, 32'h44332211, 4'b1000, 8'h33, 3'd2, 1'b1, 16'd3};
    vecs[14] = '{1'b0, 4'b1111, 32'h44332211, 4'b0000, 8'h44, 3'd3, 1'b0, 16'd4};

    for (int v = 0; v < 15; v++) begin
      cycle(vecs[v].rst, vecs[v].req, vecs[v].wdata);
      chk($sformatf("vec%0d_gnt", v),   32'(gnt),      32'(vecs[v].exp_gnt));
      chk($sformatf("vec%0d_q", v),     32'(q),        32'(vecs[v].exp_q));
      chk($sformatf("vec%0d_owner", v), 32'(owner),    32'(vecs[v].exp_owner));
      chk($sformatf("vec%0d_busy", v),  32'(busy),     32'(vecs[v].exp_busy));
      chk($sformatf("vec%0d_cnt", v),   32'(wr_count), 32'(vecs[v].exp_cnt));
    end

    // --- withdrawal: requester 1 drops req during its GRANT cycle --------
    // pointer is back at 0 after the rotation above
    cycle(1'b0, 4'b0010, 32'h00005A00);
    chk("wd_gnt", 32'(gnt), 32'h2);
    cycle(1'b0, 4'b0000, 32'h00005A00);
    chk("wd_q",     32'(q),        32'h5A);
    chk("wd_owner", 32'(owner),    32'd1);
    chk("wd_cnt",   32'(wr_count), 32'd5);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 4'b0000, 32'h00005A00);
      chk($sformatf("wd_nogrant%0d", i), 32'(gnt), 32'h0);
      chk($sformatf("wd_idle%0d", i),    32'(busy), 32'h0);
    end

    // --- reset during GRANT drops the write ------------------------------
    cycle(1'b0, 4'b0001, 32'h0000003C);
    chk("rg_gnt", 32'(gnt), 32'h1);
    cycle(1'b1, 4'b0001, 32'h0000003C);
    chk("rg_q",    32'(q),        32'h0);
    chk("rg_cnt",  32'(wr_count), 32'h0);
    chk("rg_busy", 32'(busy),     32'h0);
    cycle(1'b0, 4'b0000, 32'h0000003C);
    chk("rg_idle", 32'(busy), 32'h0);
    chk("rg_q2",   32'(q),    32'h0);

    // --- saturation: preload the counter then do 3 writes -----------------
    @(negedge clk);
    force dut.r_wr_count = 16'hFFFE;
    #1;
    release dut.r_wr_count;
    m_cnt = 32'hFFFE;
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 4'b1000, 32'h77000000);
      cycle(1'b0, 4'b1000, 32'h77000000);
      check_model($sformatf("sat%0d", i));
      chk($sformatf("sat%0d_abs", i), 32'(wr_count), 32'hFFFF);
    end

    // --- random traffic against the model ---------------------------------
    cycle(1'b1, 4'b0000, 32'h0);
    check_model("rnd_rst");
    for (int n = 0; n < 400; n++) begin
      logic        r;
      logic [3:0]  rq;
      logic [31:0] wd;
      r  = ($urandom_range(0, 39) == 0);
      rq = 4'($urandom);
      wd = $urandom;
      cycle(r, rq, wd);
      check_model($sformatf("rnd%0d", n));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
